// File: rtl/if_id_pipe.sv
// if_id_pipe: fetch/decode stage register with valid/ready handshake, flush and a stall counter.
// Build with IF_ID_SKID_EN defined for a 2-entry skid buffer and a registered in_ready.
module if_id_pipe #(
  parameter int unsigned     DW     = 32,
  parameter int unsigned     AW     = 32,
  parameter int unsigned     PC_INC = 4,
  parameter logic [DW-1:0]   NOP    = '0,
  parameter int unsigned     CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_ins,
  input  logic [AW-1:0] in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_ins,
  output logic [AW-1:0] out_pc,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic [DW-1:0] ins;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        w_in_entry;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_stall;

  logic          r_m_valid;
  entry_t        r_m;
  logic          w_m_valid_nxt;
  logic          w_m_load;
  entry_t        w_m_nxt;

  logic [CW-1:0] r_stall_cnt;

`ifdef IF_ID_SKID_EN
  logic          r_s_valid;
  entry_t        r_s;
  logic          r_in_ready;
  logic          w_s_valid_nxt;
  logic          w_s_load;
`endif

  // Link PC is formed at capture time and wraps modulo 2^AW.
  assign w_in_entry = '{ins: in_ins, pc: in_pc + AW'(PC_INC)};

`ifdef IF_ID_SKID_EN
  assign in_ready   = r_in_ready;
`else
  assign in_ready   = !r_m_valid || out_ready;
`endif

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_m_valid && out_ready;
  assign w_stall    = r_m_valid && !out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    w_m_valid_nxt = r_m_valid;
    w_m_load      = 1'b0;
    w_m_nxt       = w_in_entry;
`ifdef IF_ID_SKID_EN
    w_s_valid_nxt = r_s_valid;
    w_s_load      = 1'b0;
    if (flush) begin
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else if (w_out_xfer) begin
      if (r_s_valid) begin
        // The skid entry is older than anything on the input, so it moves up first.
        w_m_load      = 1'b1;
        w_m_nxt       = r_s;
        w_s_valid_nxt = 1'b0;
      end else if (w_in_xfer) begin
        w_m_load      = 1'b1;
      end else begin
        w_m_valid_nxt = 1'b0;
      end
    end else if (w_in_xfer) begin
      if (r_m_valid) begin
        w_s_load      = 1'b1;
        w_s_valid_nxt = 1'b1;
      end else begin
        w_m_load      = 1'b1;
        w_m_valid_nxt = 1'b1;
      end
    end
`else
    if (flush) begin
      w_m_valid_nxt = 1'b0;
    end else if (w_in_xfer) begin
      w_m_load      = 1'b1;
      w_m_valid_nxt = 1'b1;
    end else if (w_out_xfer) begin
      w_m_valid_nxt = 1'b0;
    end
`endif
  end

  // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
    end else begin
      r_m_valid <= w_m_valid_nxt;
    end
  end

  // NOTE: payload flops carry no reset; every output that exposes them is gated by its valid bit.
  always_ff @(posedge clk) begin
    if (w_m_load) begin
      r_m <= w_m_nxt;
    end
  end

`ifdef IF_ID_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_s_valid  <= w_s_valid_nxt;
      r_in_ready <= !w_s_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_load) begin
      r_s <= w_in_entry;
    end
  end
`endif

  // Stall counter survives flush so redirect-heavy code still shows decoder pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_m_valid;
  assign out_ins   = r_m_valid ? r_m.ins : NOP;
  assign out_pc    = r_m_valid ? r_m.pc  : '0;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: randomized and directed checks of if_id_pipe against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_id_pipe;

  localparam int          PC_INC    = 4;
  localparam int          CW        = 4;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          STALL_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_ins;
  logic [31:0] in_pc;

  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_ins;
  logic [31:0]   out_pc;
  logic [CW-1:0] stall_cnt;

  logic        w16_in_ready;
  logic        w16_out_valid;
  logic [31:0] w16_out_ins;
  logic [15:0] w16_out_pc;
  logic [15:0] w16_stall_cnt;

  if_id_pipe #(.DW(32), .AW(32), .PC_INC(PC_INC), .NOP(NOP), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  if_id_pipe #(.DW(32), .AW(16), .PC_INC(2), .CW(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w16_in_ready), .in_ins(in_ins), .in_pc(in_pc[15:0]),
    .out_valid(w16_out_valid), .out_ready(out_ready), .out_ins(w16_out_ins), .out_pc(w16_out_pc),
    .stall_cnt(w16_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   n_total;
  int   n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model acceptance: skid build holds up to two, plain build accepts when empty or draining.
  function automatic logic model_ready(input logic ordy);
`ifdef IF_ID_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  task automatic compare();
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic        e_valid;
    e_valid = q.size() != 0;
    e_ins   = NOP;
    e_pc    = '0;
    if (e_valid) begin
      e_ins = q[0].ins;
      e_pc  = q[0].pc;
    end
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out_ins",   64'(out_ins),   64'(e_ins));
    check("out_pc",    64'(out_pc),    64'(e_pc));
    check("in_ready",  64'(in_ready),  64'(model_ready(out_ready)));
    check("stall_cnt", 64'(stall_cnt), 64'(cnt));
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic mv;
    logic rdy;
    @(negedge clk);
    in_valid  = v;
    in_ins    = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    compare();
    mv  = q.size() != 0;
    rdy = model_ready(ordy);
    if (mv && !ordy && cnt < STALL_MAX) cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (mv && ordy) void'(q.pop_front());
      if (v && rdy) q.push_back('{ins: ins, pc: pc + 32'(PC_INC)});
    end
  endtask

  initial begin
    logic [31:0] r_pc;
    n_total   = 0;
    n_bad     = 0;
    cnt       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ins    = '0;
    in_pc     = '0;
    #1;
    compare();
    #11 rst_n = 1'b1;

    // Streaming at full rate.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h1000_0000 + 32'(i), 32'h0040_0000 + 32'(4 * i), 1'b1, 1'b0);

    // Backpressure for three cycles, then drain.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h2000_0000 + 32'(i), 32'h0050_0000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with entries held, then flush while the output is consumed.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h3000_0000 + 32'(i), 32'h0060_0000 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'h0070_0000, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 32'h3100_0000 + 32'(i), 32'h0061_0000 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'hBAD0_0001, 32'h0071_0000, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // PC wrap on both widths.
    step(1'b1, 32'h4000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(1'b1, 32'h4000_0001, 32'h0000_FFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("w16_out_valid", 64'(w16_out_valid), 64'd1);
    check("w16_out_pc",    64'(w16_out_pc),    64'h0001);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Counter saturation under a long stall.
    step(1'b1, 32'h5000_0000, 32'h0080_0000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));

    // Asynchronous reset with entries held: outputs clear without an edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ins",   64'(out_ins),   64'(NOP));
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    q.delete();
    cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Randomized traffic with occasional flushes and wrapping PCs.
    for (int i = 0; i < 400; i++) begin
      r_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      step($urandom_range(0, 3) != 0, $urandom, r_pc,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
